// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative divide sequencer.
// Holds the state encoding, the iteration count and the two's complement helpers.
package div_seq_pkg;

    localparam int DATA_W     = 32;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

    // Magnitude of a value, taken only when it is treated as signed.
    function automatic logic [DATA_W-1:0] absIf(input logic [DATA_W-1:0] v, input logic en);
        return (en && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic [DATA_W-1:0] negIf(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration.
// Shifts {rem, dvd} left by one and keeps the trial subtraction when it does not go negative.
module div_step
    import div_seq_pkg::*;
(
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_dvd,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_dvd,
    output logic              o_qBit
);

    logic [DATA_W:0] w_remShift;
    logic [DATA_W:0] w_trial;

    // rem < divisor on entry, so the shifted remainder fits in 33 bits and the sign of the trial is exact.
    assign w_remShift = {i_rem, i_dvd[DATA_W-1]};
    assign w_trial    = w_remShift - {1'b0, i_divisor};
    assign o_qBit     = ~w_trial[DATA_W];
    assign o_rem      = o_qBit ? w_trial[DATA_W-1:0] : w_remShift[DATA_W-1:0];
    assign o_dvd      = {i_dvd[DATA_W-2:0], o_qBit};

endmodule

// File: rtl/div_seq.sv
// Iterative 32-bit divide sequencer (DIV / DIVU) for the EX stage.
// Stalls the pipeline while iterating and presents quotient (LO) and remainder (HI) in the DONE cycle.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DIV_CYCLES_P = DIV_CYCLES
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_signed_div,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_operand_1,
    input  logic [DATA_W-1:0] i_operand_2,
    output logic              o_stall_req,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder
);

    divState_t         r_state;
    logic [CNT_W-1:0]  r_counter;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_divisor;
    logic              r_qNeg;
    logic              r_rNeg;
    logic              r_done;
    logic [DATA_W-1:0] r_quotient;
    logic [DATA_W-1:0] r_remainder;

    logic [DATA_W-1:0] w_nextRem;
    logic [DATA_W-1:0] w_nextDvd;
    logic              w_qBit;
    logic              w_lastIter;

    div_step u_step (
        .i_rem     (r_rem),
        .i_dvd     (r_dvd),
        .i_divisor (r_divisor),
        .o_rem     (w_nextRem),
        .o_dvd     (w_nextDvd),
        .o_qBit    (w_qBit)
    );

    assign w_lastIter  = (r_counter == CNT_W'(DIV_CYCLES_P - 1));
    assign o_stall_req = ((r_state == DIV_IDLE) && i_start && !i_flush) || (r_state == DIV_RUN);
    assign o_done      = r_done;
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;

    // Flush only returns to IDLE; the last delivered result stays visible for HI/LO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= DIV_IDLE;
            r_counter   <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_divisor   <= '0;
            r_qNeg      <= 1'b0;
            r_rNeg      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (i_flush) begin
            r_state <= DIV_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        if (i_operand_2 == '0) begin
                            r_state     <= DIV_DONE;
                            r_done      <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= i_operand_1;
                        end else begin
                            r_state   <= DIV_RUN;
                            r_counter <= '0;
                            r_rem     <= '0;
                            r_dvd     <= absIf(i_operand_1, i_signed_div);
                            r_divisor <= absIf(i_operand_2, i_signed_div);
                            r_qNeg    <= i_signed_div & (i_operand_1[DATA_W-1] ^ i_operand_2[DATA_W-1]);
                            r_rNeg    <= i_signed_div & i_operand_1[DATA_W-1];
                        end
                    end
                end
                DIV_RUN: begin
                    r_rem     <= w_nextRem;
                    r_dvd     <= w_nextDvd;
                    r_counter <= r_counter + CNT_W'(1);
                    // The final iteration's step outputs are the unsigned result; fix up the signs on the way out.
                    if (w_lastIter) begin
                        r_state     <= DIV_DONE;
                        r_done      <= 1'b1;
                        r_quotient  <= negIf({r_dvd[DATA_W-2:0], w_qBit}, r_qNeg);
                        r_remainder <= negIf(w_nextRem, r_rNeg);
                    end
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divide sequencer for the EX stage. It accepts the two operands that ID places on the operand path (operand_1 is the dividend, operand_2 is the divisor) and runs a radix-2 restoring division over 32 cycles. It holds the pipeline through its stall request while running, then presents quotient and remainder for the HI/LO write. Both signed (DIV) and unsigned (DIVU) forms are supported, and the block is flushable on exception or branch redirect.

## Interface
Parameters:
- DIV_CYCLES, 32: number of iteration cycles; it equals the data width and is not meant to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a divide; sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- flush  in  1  abort any operation; highest priority after rst.
- operand_1  in  `DATA_BUS  dividend; sampled with start.
- operand_2  in  `DATA_BUS  divisor; sampled with start.
- stall_req  out  1  combinational: (state==IDLE && start && !flush) || state==RUN.
- done  out  1  registered; high for exactly the one DONE cycle.
- quotient  out  `DATA_BUS  LO value; registered.
- remainder  out  `DATA_BUS  HI value; registered.

## Operation
- States: IDLE, RUN, DONE. Reset: state=IDLE, counter=0, done=0, quotient=0, remainder=0.
- IDLE, start=1, divisor≠0: latch |dividend| and |divisor| (absolute values only when signed_div=1). Latch the result sign: q_neg = dividend[31]^divisor[31] and r_neg = dividend[31], both only when signed. Clear the partial remainder and set counter=0. Go to RUN.
- IDLE, start=1, divisor=0: go directly to DONE. Outputs are quotient=32'hFFFF_FFFF and remainder=operand_1 unmodified, for both signed and unsigned.
- RUN, each cycle: shift {rem, dvd} left by 1 and compute trial = rem − divisor on 33 bits.
  - trial non-negative: rem = trial and shift in a quotient bit of 1.
  - trial negative: keep rem and shift in a 0.
  - Increment counter. After the iteration with counter==DIV_CYCLES−1, go to DONE.
- Entry to DONE: load quotient/remainder, negated (two's complement) per q_neg/r_neg. Set done=1.
- DONE: done=1 and outputs valid. Next state is always IDLE, and start is ignored in this state.
- Signed overflow: 0x8000_0000 / −1 gives quotient=0x8000_0000 and remainder=0 through the normal path, with no trap.
- start while in RUN or DONE is ignored, and operands are not re-sampled.
- quotient/remainder hold their last values until the next DONE entry. They are not modified by flush.
- flush=1 in any state: next state is IDLE and done=0 next cycle. If start and flush are asserted together in IDLE, the operation is not accepted.
- rst has priority over flush and start.

## Timing
- Start sampled in IDLE at cycle T (nonzero divisor): RUN spans T+1..T+32, and DONE with done=1 and valid results occurs at T+33. The block is back in IDLE at T+34.
- Zero divisor: DONE at T+1, IDLE at T+2.
- stall_req is high from T through T+32 and low at T+33. This lets the divide instruction advance in the DONE cycle, and HI/LO are written from quotient/remainder in that cycle.
- Back-to-back divides: the next start can be accepted at T+34 at the earliest.
- Flush mid-RUN at cycle F: IDLE at F+1, with stall_req low from F+1.

## Structure
- Shared header div.v holds:
  - state encodings DIV_IDLE, DIV_RUN, DIV_DONE (2 bits);
  - DIV_CYCLES;
  - counter width (6 bits).
  DATA_BUS comes from bus.v.
- One natural sub-module: div_step, a combinational single iteration. Inputs are rem, dvd and divisor; outputs are next rem, next dvd and the quotient bit. It is instantiated once.
- The FSM, operand latching and sign fix-up live in div_seq.

## Test plan
- DIVU 100 / 7, start at T: done at T+33 with quotient=14 and remainder=2; stall_req high T..T+32.
- DIV −7 / 2 (0xFFFF_FFF9, 2): quotient=0xFFFF_FFFD (−3) and remainder=0xFFFF_FFFF (−1); also DIV 7 / −2 gives quotient −3, remainder 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF: quotient=0x8000_0000 and remainder=0 at T+33.
- DIVU 0x1234 / 0: done at T+1 with quotient=0xFFFF_FFFF and remainder=0x1234; IDLE at T+2.
- Flush at T+10 during a DIVU: IDLE at T+11, done never asserted, quotient/remainder keep the prior result; a start with a new operation at T+12 completes correctly at T+45.
- Start pulsed during RUN with different operands: ignored, and the original result is delivered. Reset asserted mid-RUN: all outputs 0 and IDLE next cycle.
